multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameters: none; state encoding fixed per REQ-012.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 opcode  in  4  instruction bits [31:28] from the instruction register.
REQ-005 cond  in  2  branch condition, instruction bits [27:26]: 00 always, 01 EQ, 10 NE, 11 LT.
REQ-006 z, c, n, v  in  1 each  registered ALU flags from the datapath flag register.
REQ-007 pc_write, ir_write, mem_read, mem_write, reg_write, flags_write  out  1 each  datapath strobes.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 reg_dst  out  1  write-register select: 0 = rt field, 1 = rd field; mem_to_reg  out  1: 0 = ALUOut, 1 = MDR.
REQ-010 alu_src_a  out  1 (0 = PC, 1 = A); alu_src_b  out  2 (00 = B, 01 = constant 1, 10 = sign-extended imm, 11 = zero); alu_op  out  3 (ALU operation code); pc_src  out  2 (00 = ALU result, 01 = ALUOut, 10 = jump target).
REQ-011 state  out  4  current state code; halted  out  1  high in HALT.

Function
REQ-012 Moore FSM with states FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, HALT=11; codes 12-15 SHALL return to FETCH on the next edge.
REQ-013 Every output not explicitly asserted in a state SHALL be 0.
REQ-014 FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00, pc_write=1; next DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=10, alu_op=000 (branch target into ALUOut); next state decoded from opcode.
REQ-016 opcode 0xxx (data-processing) -> EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=opcode[2:0], flags_write=1.
REQ-017 From EXEC_R: opcode 0010 (CMP) and 0101 (TST) -> FETCH; all other 0xxx -> ALU_WB.
REQ-018 1000 ADDI -> EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000, flags_write=1; next ALU_WB.
REQ-019 ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 if reached from EXEC_R, 0 if from EXEC_I; next FETCH.
REQ-020 1001 LW / 1010 SW -> MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; next MEM_RD (LW) or MEM_WR (SW).
REQ-021 MEM_RD: mem_read=1, iord=1; next MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-022 MEM_WR: mem_write=1, iord=1; next FETCH.
REQ-023 1011 B -> BRANCH: pc_src=01, pc_write = taken, where taken = 1 (00), z (01), ~z (10), n^v (11); next FETCH.
REQ-024 1100 JMP -> JUMP: pc_src=10, pc_write=1; next FETCH.
REQ-025 1101 HALT -> HALT: halted=1, all strobes 0; HALT SHALL persist until rst.
REQ-026 opcodes 1110, 1111 SHALL act as NOP: DECODE -> FETCH, no strobes.
REQ-027 Instruction latency in cycles, FETCH inclusive: R-type 4, CMP/TST 3, ADDI 4, LW 5, SW 4, B 3, JMP 3, NOP 2.
REQ-028 opcode and cond SHALL be sampled combinationally from the IR; the controller SHALL NOT latch them, and the IR SHALL be stable after FETCH.
REQ-029 c is unused for branch decisions and SHALL have no effect on any output.

Reset
REQ-030 rst high at a rising edge SHALL load state=FETCH from any state, including HALT and mid-instruction states.
REQ-031 While rst is high, pc_write, ir_write, mem_write, reg_write and flags_write SHALL be forced to 0 regardless of state.
REQ-032 In the first cycle after rst deasserts, the FSM SHALL be in FETCH with the REQ-014 outputs.

Verification
REQ-033 Reset, then opcode=0000 -> states 0,1,2,4,0; reg_write=1 with reg_dst=1 only in state 4; flags_write=1 only in state 2.
REQ-034 opcode=1001 -> states 0,1,5,6,7,0; iord=1 and mem_read=1 in state 6; mem_to_reg=1 and reg_write=1 in state 7.
REQ-035 opcode=1011, cond=01: z=1 -> pc_write=1 and pc_src=01 in state 9; z=0 -> pc_write=0 in state 9; cond=11 with n=1, v=0 -> taken.
REQ-036 opcode=0010 -> states 0,1,2,0; reg_write stays 0 throughout.
REQ-037 opcode=1101 -> state 11 with halted=1 for 20+ cycles, no strobes; rst pulse -> FETCH next edge, halted=0.
REQ-038 rst asserted during MEM_WR -> mem_write=0 in that cycle; state=0 after the edge.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - Moore control FSM for a multi-cycle datapath.
// Outputs are registered alongside the state; write strobes are masked while rst is high.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [1:0] cond,
  input  logic       z,
  input  logic       c,
  input  logic       n,
  input  logic       v,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       flags_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       flags_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   taken;

  // The carry flag plays no part in any branch decision.
  logic unused_c;
  assign unused_c = c;

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      2'b00: taken = 1'b1;
      2'b01: taken = z;
      2'b10: taken = ~z;
      2'b11: taken = n ^ v;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        casez (opcode)
          4'b0???: state_d = S_EXEC_R;
          4'b1000: state_d = S_EXEC_I;
          4'b1001: state_d = S_MEM_ADDR;
          4'b1010: state_d = S_MEM_ADDR;
          4'b1011: state_d = S_BRANCH;
          4'b1100: state_d = S_JUMP;
          4'b1101: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = (opcode == 4'b0010 || opcode == 4'b0101) ? S_FETCH : S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode == 4'b1001) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    if (rst) begin
      state_d = S_FETCH;
    end
  end

  // Outputs are decoded from the state being entered so they line up with it.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.pc_write  = 1'b1;
      end
      S_DECODE: ctrl_d.alu_src_b = 2'b10;
      S_EXEC_R: begin
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_op      = opcode[2:0];
        ctrl_d.flags_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_src_b   = 2'b10;
        ctrl_d.flags_write = 1'b1;
      end
      S_ALU_WB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = (state_q == S_EXEC_R);
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.pc_src   = 2'b01;
        ctrl_d.pc_write = taken;
      end
      S_JUMP: begin
        ctrl_d.pc_src   = 2'b10;
        ctrl_d.pc_write = 1'b1;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ctrl_q  <= ctrl_d;
  end

  assign pc_write    = ctrl_q.pc_write    & ~rst;
  assign ir_write    = ctrl_q.ir_write    & ~rst;
  assign mem_write   = ctrl_q.mem_write   & ~rst;
  assign reg_write   = ctrl_q.reg_write   & ~rst;
  assign flags_write = ctrl_q.flags_write & ~rst;
  assign mem_read    = ctrl_q.mem_read;
  assign iord        = ctrl_q.iord;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_op      = ctrl_q.alu_op;
  assign pc_src      = ctrl_q.pc_src;
  assign halted      = ctrl_q.halted;
  assign state       = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - Scoreboard bench for multi_cycle_controller.
// Stimulus pushes expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [1:0] cond;
  logic       z, c, n, v;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, flags_write;
  logic       iord, reg_dst, mem_to_reg, alu_src_a, halted;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  int compared = 0;
  int mismatched = 0;
  logic [21:0] exp_q[$];
  logic [21:0] act;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond),
    .z(z), .c(c), .n(n), .v(v),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .flags_write(flags_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .state(state), .halted(halted)
  );

  assign act = {state, pc_write, ir_write, mem_read, mem_write, reg_write, flags_write,
                iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, halted};

  // Reference: per-state output table taken straight from the instruction semantics.
  function automatic logic [21:0] model(input int st, input logic [3:0] op, input logic [1:0] cd,
                                        input logic zz, input logic nn, input logic vv, input logic r);
    logic pcw, irw, mr, mw, rw, fw, io, rd, m2r, asa, hl;
    logic [1:0] asb, ps;
    logic [2:0] aop;
    logic [3:0] s4;
    {pcw, irw, mr, mw, rw, fw, io, rd, m2r, asa, hl} = '0;
    asb = 2'b00; ps = 2'b00; aop = 3'b000;
    s4 = st[3:0];
    case (st)
      0:  begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
      1:  asb = 2'b10;
      2:  begin asa = 1; aop = op[2:0]; fw = 1; end
      3:  begin asa = 1; asb = 2'b10; fw = 1; end
      4:  begin rw = 1; rd = (op < 4'd8); end
      5:  begin asa = 1; asb = 2'b10; end
      6:  begin mr = 1; io = 1; end
      7:  begin rw = 1; m2r = 1; end
      8:  begin mw = 1; io = 1; end
      9:  begin ps = 2'b01; pcw = (cd == 0) ? 1'b1 : (cd == 1) ? zz : (cd == 2) ? !zz : (nn != vv); end
      10: begin ps = 2'b10; pcw = 1; end
      11: hl = 1;
      default: ;
    endcase
    if (r) begin pcw = 0; irw = 0; mw = 0; rw = 0; fw = 0; end
    return {s4, pcw, irw, mr, mw, rw, fw, io, rd, m2r, asa, asb, aop, ps, hl};
  endfunction

  // rst_at: cycle index (from FETCH) on which rst is held high, aborting the instruction.
  task automatic run_instr(input logic [3:0] op, input logic [1:0] cd, input logic zz,
                           input logic nn, input logic vv, input int rst_at, input int hold);
    int path[$];
    opcode = op; cond = cd; z = zz; n = nn; v = vv;
    if (op < 4'd8) path = (op == 4'd2 || op == 4'd5) ? '{0, 1, 2} : '{0, 1, 2, 4};
    else if (op == 4'd8)  path = '{0, 1, 3, 4};
    else if (op == 4'd9)  path = '{0, 1, 5, 6, 7};
    else if (op == 4'd10) path = '{0, 1, 5, 8};
    else if (op == 4'd11) path = '{0, 1, 9};
    else if (op == 4'd12) path = '{0, 1, 10};
    else if (op == 4'd13) begin
      path = '{0, 1};
      for (int i = 0; i < hold; i++) path.push_back(11);
    end
    else path = '{0, 1};
    for (int k = 0; k < path.size(); k++) begin
      rst = (k == rst_at);
      c = 1'($urandom);
      exp_q.push_back(model(path[k], op, cd, zz, nn, vv, rst));
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL cycle_check t=%0t got=%h want=%h (state got=%0d want=%0d)",
                   $time, act, e, act[21:18], e[21:18]);
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    int ra, len;
    rst = 1'b1; opcode = 4'd0; cond = 2'd0; z = 0; c = 0; n = 0; v = 0;
    @(posedge clk); #1;
    repeat (2) begin
      exp_q.push_back(model(0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      @(posedge clk); #1;
    end
    rst = 1'b0;

    run_instr(4'd0,  2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd9,  2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd11, 2'd1, 1, 0, 0, -1, 0);
    run_instr(4'd11, 2'd1, 0, 0, 0, -1, 0);
    run_instr(4'd11, 2'd3, 0, 1, 0, -1, 0);
    run_instr(4'd11, 2'd3, 1, 1, 1, -1, 0);
    run_instr(4'd2,  2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd5,  2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd8,  2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd12, 2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd14, 2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd15, 2'd0, 0, 0, 0, -1, 0);
    run_instr(4'd10, 2'd0, 0, 0, 0, 3, 0);
    run_instr(4'd13, 2'd0, 0, 0, 0, 23, 22);
    run_instr(4'd7,  2'd0, 0, 0, 0, -1, 0);

    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd13 && $urandom_range(0, 3) != 0) op = 4'd1;
      len = (op == 4'd9) ? 5 : 4;
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : -1;
      if (op == 4'd13) run_instr(op, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                 21 + $urandom_range(0, 3), 22 + $urandom_range(0, 3));
      else run_instr(op, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ra, 0);
    end

    repeat (2) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
